// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared multiply/divide unit: start, latency wait, HI/LO writeback, exceptions.
// Define MULDIV_OVF_EXC_EN to turn multiplier overflow into an exception instead of a write.
module muldiv_sequencer #(
    parameter int DIV_CYCLES  = 32,
    parameter int MULT_CYCLES = 1,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_div,
    input  logic [31:0] operand_b,
    input  logic        mult_overflow,
    input  logic        abort,
    output logic        do_div,
    output logic        div_mult,
    output logic        hi_write,
    output logic        lo_write,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        mult_ovf_exc
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] DIV_START = 3'd1;
    localparam logic [2:0] DIV_RUN   = 3'd2;
    localparam logic [2:0] MULT_RUN  = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;
    localparam logic [2:0] DIV_ZERO  = 3'd5;
    localparam logic [2:0] MULT_OVF  = 3'd6;

    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_mult_q, div_mult_d;
    logic             last_mult_cycle_ovf;

`ifdef MULDIV_OVF_EXC_EN
    assign last_mult_cycle_ovf = mult_overflow;
`else
    logic unused_mult_overflow;
    assign unused_mult_overflow = mult_overflow;
    assign last_mult_cycle_ovf  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_mult_d = div_mult_q;
        // Abort overrides everything, including a start arriving in the same cycle.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        div_mult_d = ~op_div;
                        if (op_div) begin
                            state_d = (operand_b == 32'd0) ? DIV_ZERO : DIV_START;
                        end else begin
                            state_d = MULT_RUN;
                            cnt_d   = MULT_LOAD;
                        end
                    end
                end
                DIV_START: begin
                    state_d = DIV_RUN;
                    cnt_d   = DIV_LOAD;
                end
                DIV_RUN: begin
                    if (cnt_q == '0) begin
                        state_d = WRITEBACK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                MULT_RUN: begin
                    if (cnt_q == '0) begin
                        state_d = last_mult_cycle_ovf ? MULT_OVF : WRITEBACK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                WRITEBACK, DIV_ZERO, MULT_OVF: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_mult_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_mult_q <= div_mult_d;
        end
    end

    // Outputs decode the state register; only the strobes see abort combinationally.
    assign busy         = (state_q != IDLE);
    assign do_div       = (state_q == DIV_START);
    assign div_mult     = div_mult_q;
    assign hi_write     = (state_q == WRITEBACK) & ~abort;
    assign lo_write     = (state_q == WRITEBACK) & ~abort;
    assign div_zero_exc = (state_q == DIV_ZERO) & ~abort;
    assign done         = ((state_q == WRITEBACK) | (state_q == DIV_ZERO) |
                           (state_q == MULT_OVF)) & ~abort;

`ifdef MULDIV_OVF_EXC_EN
    assign mult_ovf_exc = (state_q == MULT_OVF) & ~abort;
`else
    assign mult_ovf_exc = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; completions are scored against a queue of expected results.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_div;
    logic [31:0] operand_b;
    logic        mult_overflow;
    logic        abort;
    logic        do_div, div_mult, hi_write, lo_write, busy, done, div_zero_exc, mult_ovf_exc;

    typedef struct {
        string tag;
        int    at_cycle;
        logic  wr;
        logic  dz;
        logic  ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   c0;

    muldiv_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .op_div        (op_div),
        .operand_b     (operand_b),
        .mult_overflow (mult_overflow),
        .abort         (abort),
        .do_div        (do_div),
        .div_mult      (div_mult),
        .hi_write      (hi_write),
        .lo_write      (lo_write),
        .busy          (busy),
        .done          (done),
        .div_zero_exc  (div_zero_exc),
        .mult_ovf_exc  (mult_ovf_exc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic void expect_done(input string tag, input int at, input logic wr,
                                        input logic dz, input logic ovf);
        exp_t e;
        e.tag      = tag;
        e.at_cycle = at;
        e.wr       = wr;
        e.dz       = dz;
        e.ovf      = ovf;
        sb_q.push_back(e);
    endfunction

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_done observed=1 expected=0 cycle=%0d", cyc);
            end
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check({mon_e.tag, "_cycle"}, 32'(cyc), 32'(mon_e.at_cycle));
                check({mon_e.tag, "_hi"}, 32'(hi_write), 32'(mon_e.wr));
                check({mon_e.tag, "_lo"}, 32'(lo_write), 32'(mon_e.wr));
                check({mon_e.tag, "_dz"}, 32'(div_zero_exc), 32'(mon_e.dz));
                check({mon_e.tag, "_ovf"}, 32'(mult_ovf_exc), 32'(mon_e.ovf));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; start = 1'b0; op_div = 1'b0; operand_b = 32'd0;
        mult_overflow = 1'b0; abort = 1'b0;
        #3;
        check("reset_outs", 32'({do_div, div_mult, hi_write, lo_write, busy, done,
                                div_zero_exc, mult_ovf_exc}), 32'd0);
        #9 reset = 1'b1;
        tick();

        // Divide by 7: done in cycle 34, stray start in cycle 5 ignored.
        c0 = cyc;
        start = 1'b1; op_div = 1'b1; operand_b = 32'd7;
        expect_done("div7", c0 + 34, 1'b1, 1'b0, 1'b0);
        #1 check("div7_c0_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        check("div7_c1", 32'({do_div, busy, div_mult}), 32'b110);
        tick();
        for (int k = 2; k < 34; k++) begin
            start  = (k == 5);
            op_div = (k == 5) ? 1'b0 : 1'b1;
            #1 check($sformatf("div7_run_c%0d", k), 32'({busy, done, do_div, div_mult, hi_write}),
                     32'b10000);
            tick();
        end
        start = 1'b0;
        check("div7_c34", 32'({hi_write, lo_write, done, busy}), 32'b1111);
        tick();

        // Back-to-back multiply in the cycle after done.
        check("div7_c35_idle", 32'({busy, done}), 32'b00);
        c0 = cyc;
        start = 1'b1; op_div = 1'b0; operand_b = 32'd3;
        expect_done("mult_b2b", c0 + 2, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        check("mult_c1", 32'({div_mult, busy, do_div, done}), 32'b1100);
        tick();
        check("mult_c2", 32'({hi_write, lo_write, done, do_div}), 32'b1110);
        tick();
        check("mult_c3", 32'({busy, div_mult}), 32'b01);
        check("mult_sb_empty", 32'(sb_q.size()), 32'd0);

        // Divide by zero.
        c0 = cyc;
        start = 1'b1; op_div = 1'b1; operand_b = 32'd0;
        expect_done("divzero", c0 + 1, 1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        check("divzero_c1", 32'({div_zero_exc, done, hi_write, lo_write, do_div, busy, div_mult}),
              32'b1100010);
        tick();
        check("divzero_c2", 32'({busy, done, div_zero_exc}), 32'b000);

        // Abort a divide in cycle 10, then multiply from cycle 11.
        start = 1'b1; op_div = 1'b1; operand_b = 32'd5;
        tick();
        start = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        #1 check("abort_c10", 32'({busy, done, hi_write}), 32'b100);
        tick();
        abort = 1'b0;
        check("abort_c11_idle", 32'(busy), 32'd0);
        c0 = cyc;
        start = 1'b1; op_div = 1'b0;
        expect_done("mult_after_abort", c0 + 2, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        tick();
        check("mult_after_abort_c13", 32'({done, hi_write, lo_write}), 32'b111);
        tick();

        // Abort during writeback suppresses the strobes.
        start = 1'b1; op_div = 1'b0;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        #1 check("abort_wb", 32'({done, hi_write, lo_write, busy}), 32'b0001);
        tick();
        abort = 1'b0;
        check("abort_wb_idle", 32'(busy), 32'd0);

        // Abort together with start in IDLE drops the request.
        start = 1'b1; op_div = 1'b1; operand_b = 32'd0; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start", 32'({busy, div_zero_exc, done, div_mult}), 32'b0001);

        // Asynchronous reset in the middle of a divide.
        start = 1'b1; op_div = 1'b1; operand_b = 32'd9;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("rst_pre_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1 check("rst_mid_outs", 32'({do_div, div_mult, hi_write, lo_write, busy, done,
                                     div_zero_exc, mult_ovf_exc}), 32'd0);
        reset = 1'b1;
        tick();
        check("rst_after_idle", 32'(busy), 32'd0);

        // Start while busy is ignored (would be a div-by-zero if accepted).
        c0 = cyc;
        start = 1'b1; op_div = 1'b0;
        expect_done("mult_ignore", c0 + 2, 1'b1, 1'b0, 1'b0);
        tick();
        op_div = 1'b1; operand_b = 32'd0;
        #1 check("ignore_c1", 32'({busy, div_mult}), 32'b11);
        tick();
        start = 1'b0;
        check("ignore_c2", 32'({done, hi_write, div_zero_exc}), 32'b110);
        tick();
        check("ignore_c3", 32'({busy, done}), 32'b00);

        // Multiply with overflow flagged.
        c0 = cyc;
        start = 1'b1; op_div = 1'b0; mult_overflow = 1'b1;
`ifdef MULDIV_OVF_EXC_EN
        expect_done("mult_ovf", c0 + 2, 1'b0, 1'b0, 1'b1);
`else
        expect_done("mult_ovf", c0 + 2, 1'b1, 1'b0, 1'b0);
`endif
        tick();
        start = 1'b0;
        tick();
`ifdef MULDIV_OVF_EXC_EN
        check("mult_ovf_c2", 32'({done, hi_write, mult_ovf_exc}), 32'b101);
`else
        check("mult_ovf_c2", 32'({done, hi_write, mult_ovf_exc}), 32'b110);
`endif
        tick();
        mult_overflow = 1'b0;
        check("mult_ovf_c3", 32'(busy), 32'd0);

        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
